// File: rtl/llr_pe_array.sv
// llr_pe_array
// ------------
// Pipelined array of LANES LLR processing elements for a successive-
// cancellation polar decoder. Every accepted beat carries LANES pairs of
// sign-magnitude LLRs plus a mode bit. Each lane computes either the
// min-sum f function (mode 0) or the partial-sum-controlled g function
// (mode 1) with saturation to the largest representable magnitude.
//
// Pipeline: S1 registers the operands, S2 registers the results. The
// arithmetic sits between them, and the outputs come straight from S2.
//
// Handshake (both ports): a beat transfers on a rising edge where
// valid && ready are both high. A producer holds its beat stable while
// valid && !ready. in_ready is combinational from pipeline state and
// out_ready only, never from in_valid.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   in_mode    0 = f (min-sum), 1 = g
//   in_u       partial-sum bit per lane (g only)
//   in_a       upper-branch LLRs, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_b       lower-branch LLRs, same packing
//   out_valid  output beat valid
//   out_ready  downstream accepts when out_valid && out_ready
//   out_llr    result LLRs, sign-magnitude, canonical zero
//   out_sat    per-lane flag, 1 = g result was clipped
module llr_pe_array #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [LANES-1:0]              in_u,
  input  logic [LANES*DATA_WIDTH-1:0]   in_a,
  input  logic [LANES*DATA_WIDTH-1:0]   in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_llr,
  output logic [LANES-1:0]              out_sat
);

  localparam int W  = DATA_WIDTH;
  localparam int BW = LANES * DATA_WIDTH;

  // Largest magnitude, widened to the g-path arithmetic width.
  localparam logic [W:0] MAXMAG = {2'b00, {(W-1){1'b1}}};

  // One PE: returns {sat, llr}.
  function automatic logic [W:0] pe_calc(
    input logic         mode,
    input logic         u,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-2:0]      ma;
    logic [W-2:0]      mb;
    logic [W-2:0]      mag;
    logic              sgn;
    logic              sat;
    logic signed [W:0] va;
    logic signed [W:0] vb;
    logic signed [W:0] r;
    logic [W:0]        abs_r;
    ma    = a[W-2:0];
    mb    = b[W-2:0];
    mag   = '0;
    sgn   = 1'b0;
    sat   = 1'b0;
    va    = '0;
    vb    = '0;
    r     = '0;
    abs_r = '0;
    if (!mode) begin
      sgn = a[W-1] ^ b[W-1];
      mag = (ma < mb) ? ma : mb;
    end else begin
      // W+1 bits hold the full +/-(2*MAXMAG) range of the sum/difference.
      va    = a[W-1] ? -$signed({2'b00, ma}) : $signed({2'b00, ma});
      vb    = b[W-1] ? -$signed({2'b00, mb}) : $signed({2'b00, mb});
      r     = u ? (vb - va) : (vb + va);
      abs_r = r[W] ? $unsigned(-r) : $unsigned(r);
      sgn   = r[W];
      if (abs_r > MAXMAG) begin
        mag = MAXMAG[W-2:0];
        sat = 1'b1;
      end else begin
        mag = abs_r[W-2:0];
      end
    end
    // A zero result is always emitted as +0, whatever the operand signs.
    if (mag == '0) sgn = 1'b0;
    return {sat, sgn, mag};
  endfunction

  // Stage 1: operands
  logic             s1_valid;
  logic             s1_mode;
  logic [LANES-1:0] s1_u;
  logic [BW-1:0]    s1_a;
  logic [BW-1:0]    s1_b;

  // Stage 2: results
  logic             s2_valid;
  logic [BW-1:0]    s2_llr;
  logic [LANES-1:0] s2_sat;

  logic             s2_adv;
  logic [BW-1:0]    calc_llr;
  logic [LANES-1:0] calc_sat;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_adv;
  assign out_valid = s2_valid;
  assign out_llr   = s2_llr;
  assign out_sat   = s2_sat;

  always_comb begin
    calc_llr = '0;
    calc_sat = '0;
    for (int i = 0; i < LANES; i++) begin
      {calc_sat[i], calc_llr[i*W +: W]} =
        pe_calc(s1_mode, s1_u[i], s1_a[i*W +: W], s1_b[i*W +: W]);
    end
  end

  // S1 loads a new beat whenever it can pass its content on (or is empty);
  // with no new beat in that case it simply empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_u     <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_u    <= in_u;
        s1_a    <= in_a;
        s1_b    <= in_b;
      end
    end
  end

  // S2 takes S1's result when it can advance; it empties when its beat
  // leaves and S1 has nothing behind it. Data is kept while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_llr   <= '0;
      s2_sat   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_llr <= calc_llr;
        s2_sat <= calc_sat;
      end
    end
  end

endmodule

// File: tb/tb_llr_pe_array.sv
module tb_llr_pe_array;

  localparam int W      = 8;
  localparam int L      = 4;
  localparam int BW     = W * L;
  localparam int EW     = BW + L;
  localparam int MAXMAG = (1 << (W - 1)) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [L-1:0]  in_u;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_llr;
  logic [L-1:0]  out_sat;

  llr_pe_array #(.DATA_WIDTH(W), .LANES(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_u      (in_u),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_llr   (out_llr),
    .out_sat   (out_sat)
  );

  // ---------------- scoreboard state ----------------
  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc_cnt = 0;
  logic [EW-1:0] exp_q[$];
  int pop_cyc[$];
  logic          hold_prev = 1'b0;
  logic [EW-1:0] prev_got  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W:0] ref_lane(input logic mode, input logic u,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    int ma, mb, va, vb, r, m;
    bit sg, st;
    ma = int'(a[W-2:0]);
    mb = int'(b[W-2:0]);
    st = 0;
    if (!mode) begin
      m  = (ma < mb) ? ma : mb;
      sg = a[W-1] ^ b[W-1];
    end else begin
      va = a[W-1] ? -ma : ma;
      vb = b[W-1] ? -mb : mb;
      r  = u ? (vb - va) : (vb + va);
      sg = (r < 0);
      m  = (r < 0) ? -r : r;
      if (m > MAXMAG) begin
        m  = MAXMAG;
        st = 1;
      end
    end
    if (m == 0) sg = 0;
    return {st, sg, m[W-2:0]};
  endfunction

  function automatic logic [EW-1:0] ref_beat(input logic mode, input logic [L-1:0] u,
                                             input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] y;
    logic [L-1:0]  s;
    logic [W:0]    r;
    for (int i = 0; i < L; i++) begin
      r = ref_lane(mode, u[i], a[i*W +: W], b[i*W +: W]);
      s[i] = r[W];
      y[i*W +: W] = r[W-1:0];
    end
    return {s, y};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_rand(input int mode_sel);
    in_mode = (mode_sel < 0) ? 1'($urandom_range(0, 1)) : 1'(mode_sel);
    in_u    = L'($urandom_range(0, (1 << L) - 1));
    in_a    = BW'($urandom);
    in_b    = BW'($urandom);
  endtask

  // One clock: sample handshakes just before the edge, then update the
  // scoreboard. Returns at posedge + 1.
  task automatic cycle();
    logic          acc, dep;
    logic [EW-1:0] got, e_in;
    @(negedge clk);
    acc  = in_valid && in_ready;
    dep  = out_valid && out_ready;
    got  = {out_sat, out_llr};
    e_in = ref_beat(in_mode, in_u, in_a, in_b);
    if (hold_prev) chk("hold_stable", got, prev_got);
    hold_prev = out_valid && !out_ready;
    prev_got  = got;
    @(posedge clk);
    #1;
    cyc++;
    if (dep) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("out_beat", got, exp_q.pop_front());
      pop_cyc.push_back(cyc);
    end
    if (acc) begin
      exp_q.push_back(e_in);
      acc_cnt++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          mode;
    logic [L-1:0]  u;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] exp_llr;
    logic [L-1:0]  exp_sat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int a0;
    int n;
    vecs[0] = '{1'b0, 4'b0000, 32'h00_80_7F_85, 32'h00_05_FF_03, 32'h00_00_FF_83, 4'b0000};
    vecs[1] = '{1'b1, 4'b0000, 32'h10_05_E4_64, 32'h01_85_E4_64, 32'h11_00_FF_7F, 4'b0011};
    vecs[2] = '{1'b1, 4'b1111, 32'h80_05_14_64, 32'h03_05_8A_E4, 32'h03_00_9E_FF, 4'b0001};
    vecs[3] = '{1'b1, 4'b0101, 32'h3F_81_FF_7F, 32'hC0_7F_FF_7F, 32'h81_7F_FF_00, 4'b0110};
    vecs[4] = '{1'b0, 4'b1111, 32'hC0_0A_00_FF, 32'h40_8B_80_FF, 32'hC0_8A_00_7F, 4'b0000};

    in_valid  = 0;
    in_mode   = 0;
    in_u      = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1;
    rst_n     = 1;
    #1 rst_n  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_llr", out_llr, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Directed: beat presented, output visible two edges later.
    foreach (vecs[k]) begin
      in_mode  = vecs[k].mode;
      in_u     = vecs[k].u;
      in_a     = vecs[k].a;
      in_b     = vecs[k].b;
      in_valid = 1;
      @(posedge clk);
      #1;
      in_valid = 0;
      chk("vec_lat1_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("vec_valid", out_valid, 1);
      chk($sformatf("vec%0d_llr", k), out_llr, vecs[k].exp_llr);
      chk($sformatf("vec%0d_sat", k), out_sat, vecs[k].exp_sat);
      @(posedge clk);
      #1;
      chk("vec_drained", out_valid, 0);
    end

    // Streaming: 16 back-to-back beats, alternating modes.
    pop_cyc.delete();
    a0 = acc_cnt;
    for (int k = 0; k < 16; k++) begin
      drive_rand(k % 2);
      in_valid = 1;
      cycle();
    end
    in_valid = 0;
    chk("stream_accepts", 64'(acc_cnt - a0), 16);
    drain(10);
    chk("stream_outputs", 64'(pop_cyc.size()), 16);
    if (pop_cyc.size() == 16)
      chk("stream_consecutive", 64'(pop_cyc[15] - pop_cyc[0]), 15);

    // Back-pressure: stall output, present beats continuously.
    out_ready = 0;
    a0 = acc_cnt;
    drive_rand(-1);
    in_valid = 1;
    for (int k = 0; k < 6; k++) begin
      n = acc_cnt;
      cycle();
      if (acc_cnt != n) drive_rand(-1);
      if (k == 0) chk("bp_ready_after_1", in_ready, 1);
    end
    chk("bp_accepted", 64'(acc_cnt - a0), 2);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    n = acc_cnt;
    cycle();
    chk("bp_release_accept", 64'(acc_cnt - n), 1);
    in_valid = 0;
    drain(10);

    // Random traffic with random back-pressure.
    for (int k = 0; k < 400; k++) begin
      n = acc_cnt;
      out_ready = ($urandom_range(0, 9) < 6);
      if (!in_valid) begin
        if ($urandom_range(0, 9) < 7) begin
          drive_rand(-1);
          in_valid = 1;
        end
      end
      cycle();
      if (acc_cnt != n) in_valid = 0;
    end
    in_valid  = 0;
    out_ready = 1;
    drain(10);

    // Reset mid-stream with both stages full.
    out_ready = 0;
    drive_rand(-1);
    in_valid = 1;
    cycle();
    drive_rand(-1);
    cycle();
    in_valid = 0;
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_ready", in_ready, 0);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_llr", out_llr, 0);
    chk("mid_rst_out_sat", out_sat, 0);
    exp_q.delete();
    hold_prev = 0;
    @(negedge clk) rst_n = 1;
    out_ready = 1;
    cycle();
    chk("mid_post_ready", in_ready, 1);
    chk("mid_post_no_spurious", out_valid, 0);
    drive_rand(-1);
    in_valid = 1;
    cycle();
    in_valid = 0;
    chk("mid_new_lat1", out_valid, 0);
    cycle();
    chk("mid_new_lat2", out_valid, 1);
    drain(5);
    chk("mid_final_idle", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $finish;
  end

endmodule
